// File: rtl/memory_cycle.sv
// ============================================================================
// memory_cycle : M stage of the 18-bit pipeline. It performs load/store over a
//                req/ready handshake and registers the result into the W stage.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module memory_cycle #(
    parameter int DATA_W  = 18,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALU_ResultM,
    input  logic [1:0]        RGB_M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_m,
    output logic              mem_err,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RD_W,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [1:0]        RGB_W
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                regwrite_q, regwrite_d;
    logic                resultsrc_q, resultsrc_d;
    logic [4:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   readdata_q, readdata_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   pc4_q, pc4_d;
    logic [1:0]          rgb_q, rgb_d;

    logic                access_w;
    logic                in_range_w;
    logic                stall_w;
    logic                req_w;
    logic                load_w;
    logic [DATA_W-1:0]   rdsel_w;

    assign access_w   = MemWriteM | ResultSrcM;
    assign in_range_w = (ALU_ResultM[DATA_W-1:ADDR_W] == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        rd_d        = rd_q;
        readdata_d  = readdata_q;
        alu_d       = alu_q;
        pc4_d       = pc4_q;
        rgb_d       = rgb_q;
        stall_w     = 1'b0;
        req_w       = 1'b0;
        load_w      = 1'b0;
        rdsel_w     = '0;

        case (state_q)
            S_IDLE: begin
                if (access_w && in_range_w) begin
                    stall_w    = 1'b1;
                    addr_d     = ALU_ResultM[ADDR_W-1:0];
                    we_d       = MemWriteM;
                    wdata_d    = WriteDataM;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                    regwrite_d = 1'b0;
                end else begin
                    // Out-of-range accesses pass through as if no access, flagging the error.
                    load_w = 1'b1;
                    if (access_w) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == C_TIMEOUT) begin
                    load_w  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    req_w = 1'b1;
                    if (mem_ready) begin
                        load_w  = 1'b1;
                        rdsel_w = we_q ? '0 : mem_rdata;
                        state_d = S_IDLE;
                    end else begin
                        stall_w = 1'b1;
                        cnt_d   = cnt_q + C_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_w) begin
            regwrite_d  = RegWriteM;
            resultsrc_d = ResultSrcM;
            rd_d        = RD_M;
            readdata_d  = rdsel_w;
            alu_d       = ALU_ResultM;
            pc4_d       = PCPlus4M;
            rgb_d       = RGB_M;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= '0;
            readdata_q  <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            readdata_q  <= readdata_d;
            alu_q       <= alu_d;
            pc4_q       <= pc4_d;
            rgb_q       <= rgb_d;
        end
    end

    assign stall_m     = rst & stall_w;
    assign mem_req     = req_w;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_err     = err_q;
    assign RegWriteW   = regwrite_q;
    assign ResultSrcW  = resultsrc_q;
    assign RD_W        = rd_q;
    assign ReadDataW   = readdata_q;
    assign ALU_ResultW = alu_q;
    assign PCPlus4W    = pc4_q;
    assign RGB_W       = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_cycle.sv
// ============================================================================
// tb_memory_cycle : directed self-checking bench for memory_cycle.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
    logic [4:0]  RD_M = '0;
    logic [17:0] PCPlus4M = '0, WriteDataM = '0, ALU_ResultM = '0;
    logic [1:0]  RGB_M = '0;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [17:0] mem_wdata;
    logic [17:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall_m, mem_err;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [17:0] ReadDataW, ALU_ResultW, PCPlus4W;
    logic [1:0]  RGB_W;

    int n_checks = 0;
    int n_fail   = 0;

    memory_cycle #(.DATA_W(18), .ADDR_W(10), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM), .RGB_M(RGB_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_m(stall_m), .mem_err(mem_err),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .ReadDataW(ReadDataW), .ALU_ResultW(ALU_ResultW), .PCPlus4W(PCPlus4W),
        .RGB_W(RGB_W)
    );

    always #5 clk = ~clk;

    task automatic set_nop();
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = '0;
        PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0; RGB_M = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        ResultSrcM = 1'b1; ALU_ResultM = 18'h00010;
        #1;
        n_checks++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_m); end
        @(negedge clk);
        set_nop();
        n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 30'h0) begin n_fail++; $display("FAIL reset_memport: got %h want 0", {mem_req, mem_we, mem_addr, mem_wdata}); end
        n_checks++; if ({RegWriteW, ResultSrcW, RD_W, ReadDataW, ALU_ResultW, PCPlus4W, RGB_W} !== 63'h0) begin n_fail++; $display("FAIL reset_w: got %h want 0", {RegWriteW, ResultSrcW, RD_W, ReadDataW, ALU_ResultW, PCPlus4W, RGB_W}); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", mem_err); end
        rst = 1'b1;
    endtask

    task automatic test_alu_op();
        @(negedge clk);
        RegWriteM = 1'b1; RD_M = 5'd7; ALU_ResultM = 18'h00123; PCPlus4M = 18'h00044; RGB_M = 2'd2;
        #1;
        n_checks++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall_m); end
        @(negedge clk);
        set_nop();
        n_checks++; if ({RegWriteW, RD_W, ALU_ResultW, ReadDataW} !== {1'b1, 5'd7, 18'h00123, 18'h0}) begin n_fail++; $display("FAIL alu_w: got %b %0d %h %h want 1 7 00123 0", RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
        n_checks++; if ({PCPlus4W, RGB_W, mem_req} !== {18'h00044, 2'd2, 1'b0}) begin n_fail++; $display("FAIL alu_pass: got %h %0d %b want 00044 2 0", PCPlus4W, RGB_W, mem_req); end
    endtask

    task automatic test_load();
        int stalls = 0;
        @(negedge clk);
        RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd3; ALU_ResultM = 18'h0002A;
        #1;
        n_checks++; if ({stall_m, mem_req} !== 2'b10) begin n_fail++; $display("FAIL load_issue: got stall=%b req=%b want 1 0", stall_m, mem_req); end
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            mem_ready = (w == 4);
            mem_rdata = (w == 4) ? 18'h3ABCD : 18'h0;
            #1;
            if (stall_m) stalls++;
            n_checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h02A}) begin n_fail++; $display("FAIL load_port w%0d: got %b %b %h want 1 0 02a", w, mem_req, mem_we, mem_addr); end
            if (w < 4) begin
                n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL load_bubble w%0d: got %b want 0", w, RegWriteW); end
            end else begin
                n_checks++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL load_ready_stall: got %b want 0", stall_m); end
            end
        end
        n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL load_stall_cnt: got %0d want 3", stalls); end
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0; set_nop();
        n_checks++; if ({ReadDataW, RegWriteW, ResultSrcW, RD_W} !== {18'h3ABCD, 1'b1, 1'b1, 5'd3}) begin n_fail++; $display("FAIL load_w: got %h %b %b %0d want 3abcd 1 1 3", ReadDataW, RegWriteW, ResultSrcW, RD_W); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop: got %b want 0", mem_req); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        MemWriteM = 1'b1; ALU_ResultM = 18'h00100; WriteDataM = 18'h2AAAA; PCPlus4M = 18'h00008;
        #1;
        n_checks++; if (stall_m !== 1'b1) begin n_fail++; $display("FAIL st_issue_stall: got %b want 1", stall_m); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h100, 18'h2AAAA}) begin n_fail++; $display("FAIL st_port: got %b %b %h %h want 1 1 100 2aaaa", mem_req, mem_we, mem_addr, mem_wdata); end
        n_checks++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL st_ready_stall: got %b want 0", stall_m); end
        @(negedge clk);
        mem_ready = 1'b0; set_nop();
        RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd9; ALU_ResultM = 18'h00055;
        #1;
        n_checks++; if ({stall_m, mem_req} !== 2'b10) begin n_fail++; $display("FAIL ld2_issue: got stall=%b req=%b want 1 0", stall_m, mem_req); end
        n_checks++; if ({RegWriteW, ReadDataW, PCPlus4W} !== {1'b0, 18'h0, 18'h00008}) begin n_fail++; $display("FAIL st_w: got %b %h %h want 0 0 00008", RegWriteW, ReadDataW, PCPlus4W); end
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 18'h1F0F0;
        #1;
        n_checks++; if ({mem_req, mem_we, mem_addr, stall_m} !== {1'b1, 1'b0, 10'h055, 1'b0}) begin n_fail++; $display("FAIL ld2_port: got %b %b %h %b want 1 0 055 0", mem_req, mem_we, mem_addr, stall_m); end
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0; set_nop();
        n_checks++; if ({ReadDataW, RD_W, RegWriteW} !== {18'h1F0F0, 5'd9, 1'b1}) begin n_fail++; $display("FAIL ld2_w: got %h %0d %b want 1f0f0 9 1", ReadDataW, RD_W, RegWriteW); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", mem_err); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd6; ALU_ResultM = 18'h00010; PCPlus4M = 18'h00020;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmw_req: got %b want 1", mem_req); end
        rst = 1'b0;
        #1;
        n_checks++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL rmw_stall_in_rst: got %b want 0", stall_m); end
        @(negedge clk);
        rst = 1'b1; set_nop();
        mem_ready = 1'b1; mem_rdata = 18'h12345;
        #1;
        n_checks++; if ({mem_req, stall_m} !== 2'b00) begin n_fail++; $display("FAIL rmw_after: got req=%b stall=%b want 0 0", mem_req, stall_m); end
        n_checks++; if ({RegWriteW, ResultSrcW, RD_W, ReadDataW, ALU_ResultW, PCPlus4W, RGB_W} !== 63'h0) begin n_fail++; $display("FAIL rmw_w: got %h want 0", {RegWriteW, ResultSrcW, RD_W, ReadDataW, ALU_ResultW, PCPlus4W, RGB_W}); end
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        n_checks++; if ({ReadDataW, mem_req} !== {18'h0, 1'b0}) begin n_fail++; $display("FAIL rmw_late_ready: got %h %b want 0 0", ReadDataW, mem_req); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd4; ALU_ResultM = 18'h00400; PCPlus4M = 18'h00010;
        #1;
        n_checks++; if ({stall_m, mem_req} !== 2'b00) begin n_fail++; $display("FAIL oor_ld: got stall=%b req=%b want 0 0", stall_m, mem_req); end
        @(negedge clk);
        set_nop(); MemWriteM = 1'b1; ALU_ResultM = 18'h3FFFF; WriteDataM = 18'h00001;
        #1;
        n_checks++; if ({mem_err, ReadDataW, RegWriteW, ALU_ResultW} !== {1'b1, 18'h0, 1'b1, 18'h00400}) begin n_fail++; $display("FAIL oor_ld_w: got %b %h %b %h want 1 0 1 00400", mem_err, ReadDataW, RegWriteW, ALU_ResultW); end
        n_checks++; if ({stall_m, mem_req} !== 2'b00) begin n_fail++; $display("FAIL oor_st: got stall=%b req=%b want 0 0", stall_m, mem_req); end
        @(negedge clk);
        set_nop();
        repeat (3) @(negedge clk);
        n_checks++; if ({mem_err, mem_req} !== 2'b10) begin n_fail++; $display("FAIL oor_sticky: got err=%b req=%b want 1 0", mem_err, mem_req); end
    endtask

    task automatic test_timeout();
        int  stalls = 0;
        int  waits  = 0;
        bit  done   = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clr: got %b want 0", mem_err); end
        RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd5; ALU_ResultM = 18'h003FF;
        #1;
        n_checks++; if (stall_m !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b want 1", stall_m); end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            #1;
            waits++;
            if (stall_m && mem_req) stalls++;
            else done = 1'b1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL to_bound: no abort within 40 cycles"); end
        n_checks++; if (stalls !== 15) begin n_fail++; $display("FAIL to_stall_cnt: got %0d want 15", stalls); end
        n_checks++; if ({waits, mem_req, stall_m} !== {32'd16, 1'b0, 1'b0}) begin n_fail++; $display("FAIL to_abort: got cycle=%0d req=%b stall=%b want 16 0 0", waits, mem_req, stall_m); end
        @(negedge clk);
        set_nop();
        n_checks++; if ({mem_err, ReadDataW, RegWriteW, RD_W} !== {1'b1, 18'h0, 1'b1, 5'd5}) begin n_fail++; $display("FAIL to_w: got %b %h %b %0d want 1 0 1 5", mem_err, ReadDataW, RegWriteW, RD_W); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b want 0", mem_req); end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_back_to_back();
        test_reset_mid_wait();
        test_out_of_range();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_cycle.md
# memory_cycle

Memory (M) stage of the 18-bit pipelined processor. It sits directly downstream of the execute stage and consumes its M-side pipeline outputs. It performs load/store accesses to an external variable-latency data memory through a request/ready handshake, and stalls the pipeline while an access is outstanding. It registers the results into the writeback (W) pipeline register.

## Interface
Parameters:
- DATA_W, 18, datapath width
- ADDR_W, 10, data-memory word-address width (ADDR_W < DATA_W)
- TIMEOUT, 15, max WAIT cycles before an access is aborted (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- RegWriteM  in  1  register-write enable from execute stage
- MemWriteM  in  1  store request
- ResultSrcM  in  1  load request (result comes from memory)
- RD_M  in  5  destination register
- PCPlus4M  in  DATA_W  PC+4 from execute stage
- WriteDataM  in  DATA_W  store data
- ALU_ResultM  in  DATA_W  effective address / ALU result
- RGB_M  in  2  RGB tag, passed through
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  access complete
- stall_m  out  1  freeze F/D/E stages and the M inputs
- mem_err  out  1  sticky error flag (range violation or timeout)
- RegWriteW, ResultSrcW  out  1  W-stage controls
- RD_W  out  5  W-stage destination
- ReadDataW, ALU_ResultW, PCPlus4W  out  DATA_W  W-stage data
- RGB_W  out  2  W-stage RGB tag

## Operation
- access = MemWriteM | ResultSrcM. A value of MemWriteM=ResultSrcM=1 is treated as a store.
- in_range = (ALU_ResultM[DATA_W-1:ADDR_W] == 0).
- FSM states: IDLE and WAIT.
- IDLE, no access: the instruction passes through. At the clock edge the W registers load the M inputs, and ReadDataW is loaded with 0.
- IDLE, access and in_range:
  - stall_m=1.
  - At the edge, latch mem_addr=ALU_ResultM[ADDR_W-1:0], mem_we=MemWriteM, and mem_wdata=WriteDataM.
  - Clear the timeout counter, go to WAIT, and write a bubble into W (RegWriteW=0, other W fields unchanged).
- IDLE, access and not in_range: no request is issued and there is no stall.
  - Load: the W registers load normally with ReadDataW=0.
  - Store: dropped; the W registers load normally.
  - mem_err is set in either case.
- WAIT:
  - mem_req=1. mem_addr, mem_we and mem_wdata are held stable.
  - stall_m = ~mem_ready & (cnt < TIMEOUT).
  - If mem_ready=1, this is the completion cycle: stall_m=0. At the edge the W registers load the M inputs with ReadDataW = mem_we ? 0 : mem_rdata, and the FSM returns to IDLE.
  - If mem_ready=0 and cnt == TIMEOUT-1, the next cycle is the abort cycle: stall_m=0, mem_req=0, W loads with ReadDataW=0, mem_err is set, and the FSM returns to IDLE.
  - Otherwise cnt increments and the W bubble is held (RegWriteW=0).
- mem_ready is ignored in IDLE.
- mem_err clears only on reset.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE, cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0.
  - All W outputs are 0.
  - stall_m=0 while in reset.
- Reset during WAIT: mem_req falls one cycle after the reset edge. Any in-flight access is abandoned, and a late mem_ready is ignored.
- Output registration:
  - mem_req, stall_m and the W outputs are decoded from registered state plus the current M inputs and mem_ready.
  - stall_m has a combinational path from mem_ready. There is no other combinational input-to-output path to the memory port.
- Latency:
  - Non-access instruction: 1 cycle, M input to W output.
  - Access: 1 issue cycle plus N WAIT cycles, where N≥1 is the cycle in which mem_ready is first seen. The minimum is 2 cycles M→W, with 1 stall cycle.
- Abort: stall_m is asserted for TIMEOUT cycles; the W load happens on cycle TIMEOUT+1.
- Back-to-back accesses: the completion edge leaves the FSM in IDLE, and the next M instruction issues in the following cycle. There is no idle gap beyond that.
- Upstream contract: M inputs are held constant while stall_m=1.

## Test plan
- Reset mid-WAIT: issue a load, pulse rst=0 for one cycle while in WAIT → mem_req=0 one cycle after the reset edge, all W outputs 0, stall_m=0, a later mem_ready has no effect.
- ALU op (RegWriteM=1, RD_M=7, ALU_ResultM=18'h00123, no access) → next cycle RegWriteW=1, RD_W=7, ALU_ResultW=18'h00123, ReadDataW=0, stall_m never asserted.
- Load: ALU_ResultM=18'h0002A with ResultSrcM=1; memory asserts ready 3 cycles after req with rdata=18'h3ABCD.
  - Required: mem_addr=10'h02A, stall_m high for 3 cycles then low on the ready cycle.
  - Next edge: ReadDataW=18'h3ABCD, RegWriteW=1.
- Store then load back-to-back with zero-wait memory (ready in the first WAIT cycle) → each access stalls exactly 1 cycle; the write carries mem_we=1 and the correct mem_wdata; the load issues in the cycle after the store completes.
- Out-of-range load: ALU_ResultM=18'h00400 with ADDR_W=10 → mem_req never asserted, no stall, ReadDataW=0, mem_err=1 and remains 1.
- Timeout: load with mem_ready tied 0 → stall_m high for exactly 15 cycles, mem_req drops, W loads with ReadDataW=0, mem_err=1.
